// File: rtl/audio_vis_pkg.sv
// Shared screen geometry, colours, FSM encoding and pixel record for the bar plotter.
package audio_vis_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int NUM_BARS  = 32;
  localparam int BAR_W     = 5;
  localparam int WINDOW    = 256;
  localparam int BAR_IDX_W = $clog2(NUM_BARS);
  localparam logic [2:0] BAR_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LATCH, S_DRAW} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
  } pixel_t;

  // -32768 has no positive twin in 16 bits, so it saturates to 32767.
  function automatic logic [14:0] sat_abs(input logic signed [15:0] s);
    if (s == 16'sh8000) return 15'h7fff;
    return s[15] ? 15'(-s) : 15'(s);
  endfunction
endpackage

// File: rtl/audio_bar_plotter_if.sv
// Sample stream in, VGA pixel-write port and overrun flag out.
interface audio_bar_plotter_if;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               freeze;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_colour;
  logic               vga_plot;
  logic               overrun;

  modport master (output sample, sample_valid, freeze,
                  input  vga_x, vga_y, vga_colour, vga_plot, overrun);
  modport slave  (input  sample, sample_valid, freeze,
                  output vga_x, vga_y, vga_colour, vga_plot, overrun);
endinterface

// File: rtl/audio_peak_window.sv
// Peak |sample| over a fixed window; emits the clamped bar height on the window's last sample.
module audio_peak_window
  import audio_vis_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample,
  input  logic               sample_valid,
  input  logic               freeze,
  output logic [6:0]         height,
  output logic               height_valid
);
  localparam int CW = $clog2(WINDOW);

  logic [14:0]   peak, mag, peak_nxt;
  logic [CW-1:0] count;
  logic          take;

  assign take     = sample_valid & ~freeze;
  assign mag      = sat_abs(sample);
  assign peak_nxt = (mag > peak) ? mag : peak;

  // Height is combinational so the window's own last sample is folded in.
  assign height_valid = take && (count == CW'(WINDOW - 1));
  assign height       = (peak_nxt[14:8] > 7'(SCREEN_H)) ? 7'(SCREEN_H) : peak_nxt[14:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak  <= '0;
      count <= '0;
    end else if (take) begin
      peak  <= height_valid ? '0 : peak_nxt;
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/audio_bar_plotter.sv
// Turns windowed peak levels into scrolling vertical bars on a 160x120 pixel-write port.
module audio_bar_plotter
  import audio_vis_pkg::*;
(
  input  logic CLOCK_50,
  input  logic resetn,
  audio_bar_plotter_if.slave bus
);
  state_t                 state, state_nxt;
  logic [6:0]             win_height, pend_height, draw_height;
  logic                   win_valid, pending, overrun;
  logic [7:0]             cnt_a;
  logic [6:0]             cnt_b;
  logic [BAR_IDX_W-1:0]   bar_idx;
  logic                   last_a, last_b, sweeping;
  pixel_t                 pix, pix_nxt;

  audio_peak_window u_peak (
    .clk          (CLOCK_50),
    .rst_n        (resetn),
    .sample       (bus.sample),
    .sample_valid (bus.sample_valid),
    .freeze       (bus.freeze),
    .height       (win_height),
    .height_valid (win_valid)
  );

  // One-deep pending slot; LATCH empties it unless a new window lands the same cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pending     <= 1'b0;
      pend_height <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun <= win_valid & pending & (state != S_LATCH);
      if (win_valid) begin
        pending     <= 1'b1;
        pend_height <= win_height;
      end else if (state == S_LATCH) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_CLEAR;
    else         state <= state_nxt;
  end

  assign sweeping = (state == S_CLEAR) || (state == S_DRAW);
  assign last_b   = (cnt_b == 7'(SCREEN_H - 1));
  assign last_a   = (state == S_CLEAR) ? (cnt_a == 8'(SCREEN_W - 1)) : (cnt_a == 8'(BAR_W - 1));

  // Pixels are registered one cycle behind the state, so IDLE also reacts to the
  // window-ending strobe itself to keep strobe-to-first-plot at three cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (last_a && last_b)      state_nxt = S_IDLE;
      S_IDLE:  if (pending || win_valid)  state_nxt = S_LATCH;
      S_LATCH:                            state_nxt = S_DRAW;
      S_DRAW:  if (last_a && last_b)      state_nxt = S_IDLE;
      default:                            state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_a       <= '0;
      cnt_b       <= '0;
      bar_idx     <= '0;
      draw_height <= '0;
    end else begin
      if (sweeping) begin
        if (last_b) begin
          cnt_b <= '0;
          cnt_a <= last_a ? '0 : cnt_a + 1'b1;
        end else begin
          cnt_b <= cnt_b + 1'b1;
        end
      end
      if (state == S_DRAW && last_a && last_b)
        bar_idx <= (bar_idx == BAR_IDX_W'(NUM_BARS - 1)) ? '0 : bar_idx + 1'b1;
      if (state == S_LATCH)
        draw_height <= pend_height;
    end
  end

  always_comb begin
    pix_nxt      = pix;
    pix_nxt.plot = 1'b0;
    case (state)
      S_CLEAR: pix_nxt = '{x: cnt_a, y: cnt_b, colour: BG_COLOUR, plot: 1'b1};
      S_DRAW: begin
        pix_nxt.x      = 8'(bar_idx) * 8'(BAR_W) + cnt_a;
        pix_nxt.y      = cnt_b;
        pix_nxt.colour = (cnt_b >= 7'(SCREEN_H) - draw_height) ? BAR_COLOUR : BG_COLOUR;
        pix_nxt.plot   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) pix <= '0;
    else         pix <= pix_nxt;
  end

  assign bus.vga_x      = pix.x;
  assign bus.vga_y      = pix.y;
  assign bus.vga_colour = pix.colour;
  assign bus.vga_plot   = pix.plot;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_audio_bar_plotter.sv
// Bench for audio_bar_plotter: predicts every plotted pixel from window peaks and bar order.
module tb_audio_bar_plotter;
  logic clk = 1'b0;
  logic resetn = 1'b0;

  audio_bar_plotter_if bus();
  audio_bar_plotter dut (.CLOCK_50(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {int h; int t;} bar_t;

  int errors = 0, checks = 0, cyc = 0;
  int clr_left = 0, bar_pos = 0, bar_m = 0, plots = 0;
  int ovr_seen = 0, exp_ovr = 0, bars_done = 0;
  int cur_lit = 0, cur_x0 = 0, last_lit = 0, last_x0 = 0;
  int m_peak = 0, m_n = 0, m_last_h = 0;
  bar_t bars[$];
  bar_t cur;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected pixel stream: a full x-outer clear after reset, then one 600-pixel bar per queued height.
  always @(negedge clk) begin
    int ex, ey, ec, idx;
    bit skip;
    if (resetn) begin
      if (bus.overrun) ovr_seen++;
      if (bus.vga_plot) begin
        plots++;
        skip = 0;
        ex = 0; ey = 0; ec = 0;
        if (clr_left > 0) begin
          idx = 19200 - clr_left;
          ex = idx / 120; ey = idx % 120; ec = 0;
          clr_left--;
        end else if (bar_pos == 0 && bars.size() == 0) begin
          check("spurious_plot", 1, 0);
          skip = 1;
        end else begin
          if (bar_pos == 0) begin
            cur = bars.pop_front();
            cur_lit = 0;
            cur_x0 = int'(bus.vga_x);
            if (cur.t >= 0) check("bar_latency", cyc, cur.t + 3);
          end
          ex = bar_m * 5 + bar_pos / 120;
          ey = bar_pos % 120;
          ec = (ey + cur.h >= 120) ? 2 : 0;
          if (bus.vga_colour == 3'b010) cur_lit++;
          bar_pos++;
          if (bar_pos == 600) begin
            bar_pos = 0; bar_m = (bar_m + 1) % 32; bars_done++;
            last_lit = cur_lit; last_x0 = cur_x0;
          end
        end
        if (!skip) begin
          checks++;
          if (bus.vga_x !== 8'(ex) || bus.vga_y !== 7'(ey) || bus.vga_colour !== 3'(ec)) begin
            errors++;
            if (errors <= 20)
              $display("FAIL pixel #%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                       plots, bus.vga_x, bus.vga_y, bus.vga_colour, ex, ey, ec);
          end
        end
      end
    end
  end

  task automatic model_sample(input logic signed [15:0] s, input bit frz);
    int v, mag;
    bar_t b;
    if (frz) return;
    v = s;
    mag = (v == -32768) ? 32767 : ((v < 0) ? -v : v);
    if (mag > m_peak) m_peak = mag;
    m_n++;
    if (m_n == 256) begin
      m_last_h = (m_peak / 256 > 120) ? 120 : m_peak / 256;
      b.h = m_last_h;
      b.t = (clr_left == 0 && bars.size() == 0 && bar_pos == 0) ? cyc : -1;
      // Draws are blocked during the clear sweep, so a newer height replaces an undrawn one.
      if (clr_left > 0 && bars.size() > 0) begin
        bars[bars.size() - 1] = b;
        exp_ovr++;
      end else begin
        bars.push_back(b);
      end
      m_peak = 0; m_n = 0;
    end
  endtask

  task automatic strobe(input logic signed [15:0] s, input bit frz, input int gap);
    bus.sample = s; bus.freeze = frz; bus.sample_valid = 1'b1;
    model_sample(s, frz);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0; bus.freeze = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic window(input logic signed [15:0] s, input int gap);
    for (int i = 0; i < 256; i++) strobe(s, 1'b0, gap);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    bars.delete();
    bar_pos = 0; bar_m = 0; m_peak = 0; m_n = 0; clr_left = 19200; plots = 0;
    @(negedge clk);
    check("rst_plot", int'(bus.vga_plot), 0);
    check("rst_x", int'(bus.vga_x), 0);
    check("rst_y", int'(bus.vga_y), 0);
    check("rst_colour", int'(bus.vga_colour), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(clr_left == 0 && bars.size() == 0 && bar_pos == 0) && n < 25000) begin
      @(posedge clk); n++;
    end
    #1;
    check({name, "_done"}, int'(clr_left == 0 && bars.size() == 0 && bar_pos == 0), 1);
  endtask

  initial begin
    int b0, o0, cnt;
    logic signed [15:0] s;
    bit frz;
    bus.sample = '0; bus.sample_valid = 1'b0; bus.freeze = 1'b0;

    // Reset and full-screen clear
    do_reset();
    wait_idle("clear");
    check("clear_plots", plots, 19200);

    // 33 windows of 0x2000: fill all bars and wrap to bar 0
    b0 = bars_done;
    for (int w = 0; w < 33; w++) window(16'sh2000, 3);
    wait_idle("wrap");
    check("wrap_height", m_last_h, 32);
    check("wrap_bars", bars_done - b0, 33);
    check("wrap_x0", last_x0, 0);
    check("wrap_lit", last_lit, 160);

    // Reset in the middle of a bar draw
    window(16'sh7fff, 1);
    cnt = 0;
    while (bar_pos < 100 && cnt < 2000) begin @(posedge clk); cnt++; end
    check("middraw_reached", int'(bar_pos >= 100), 1);
    do_reset();

    // Two windows finish during the clear sweep: one overrun, second height (64) drawn at bar 0
    o0 = ovr_seen;
    window(16'sh1000, 1);
    window(16'sh4000, 1);
    wait_idle("clearovr");
    check("ovr_pulses", ovr_seen - o0, 1);
    check("t2_height", m_last_h, 64);
    check("t2_x0", last_x0, 0);
    check("t2_lit", last_lit, 320);

    // Saturation: 255 small samples then -32768
    for (int i = 0; i < 255; i++) strobe(16'sh0010, 1'b0, 3);
    strobe(16'sh8000, 1'b0, 3);
    wait_idle("sat");
    check("sat_height", m_last_h, 120);
    check("sat_lit", last_lit, 600);
    check("sat_x0", last_x0, 5);

    // Freeze for 100 strobes mid-window; loud frozen samples must be ignored
    for (int i = 0; i < 100; i++) strobe(16'sh1000, 1'b0, 3);
    for (int i = 0; i < 100; i++) strobe(16'sh7fff, 1'b1, 3);
    for (int i = 0; i < 156; i++) strobe(-16'sh1000, 1'b0, 3);
    wait_idle("freeze");
    check("freeze_height", m_last_h, 16);
    check("freeze_lit", last_lit, 80);

    // Random windows with random scale and sporadic freeze
    for (int w = 0; w < 3; w++) begin
      int sh;
      sh = $urandom_range(0, 12);
      cnt = 0;
      while (cnt < 256) begin
        s = 16'($urandom);
        s = s >>> sh;
        frz = ($urandom_range(0, 15) == 0);
        strobe(s, frz, 3);
        if (!frz) cnt++;
      end
    end
    wait_idle("random");

    check("overrun_total", ovr_seen, exp_ovr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
